book_level_update_tx: RTL and testbench



---
 rtl/book_level_update_tx.sv | 177 +++++++++++++++++
 tb/tb_book_level_update_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/book_level_update_tx.sv
// Turns per-order add/reduce events into absolute price-level updates for the
// top-of-book cache, using one aggregation table per side.
module book_level_update_tx #(
  parameter int N_LEVELS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_ask,
  input  logic        in_is_add,
  input  logic [47:0] in_price,
  input  logic [31:0] in_shares,
  output logic        update_valid,
  output logic        is_ask,
  output logic [47:0] price,
  output logic [31:0] new_qty,
  output logic [15:0] drop_count
);

  localparam int IW = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t state_q, state_d;

  logic        ev_is_ask_q, ev_is_ask_d;
  logic        ev_is_add_q, ev_is_add_d;
  logic [47:0] ev_price_q, ev_price_d;
  logic [31:0] ev_shares_q, ev_shares_d;

  // Index [0] is the bid table, [1] the ask table.
  logic [N_LEVELS-1:0] valid_q [2];
  logic [N_LEVELS-1:0] valid_d [2];
  logic [47:0]         lvl_price_q [2][N_LEVELS];
  logic [47:0]         lvl_price_d [2][N_LEVELS];
  logic [31:0]         lvl_qty_q [2][N_LEVELS];
  logic [31:0]         lvl_qty_d [2][N_LEVELS];

  logic        out_is_ask_q, out_is_ask_d;
  logic [47:0] out_price_q, out_price_d;
  logic [31:0] out_qty_q, out_qty_d;
  logic [15:0] drop_q, drop_d;

  logic          hit, free, emit, drop_inc;
  logic [IW-1:0] hit_idx, free_idx;
  logic [31:0]   cur_qty, emit_qty;
  logic [32:0]   sum;

  always_comb begin
    state_d      = state_q;
    ev_is_ask_d  = ev_is_ask_q;
    ev_is_add_d  = ev_is_add_q;
    ev_price_d   = ev_price_q;
    ev_shares_d  = ev_shares_q;
    valid_d      = valid_q;
    lvl_price_d  = lvl_price_q;
    lvl_qty_d    = lvl_qty_q;
    out_is_ask_d = out_is_ask_q;
    out_price_d  = out_price_q;
    out_qty_d    = out_qty_q;
    drop_d       = drop_q;
    hit          = 1'b0;
    hit_idx      = '0;
    free         = 1'b0;
    free_idx     = '0;
    emit         = 1'b0;
    emit_qty     = '0;
    drop_inc     = 1'b0;

    // Free-slot scan keeps the first hit so the lowest invalid index wins.
    for (int unsigned i = 0; i < N_LEVELS; i++) begin
      if (valid_q[ev_is_ask_q][i] && lvl_price_q[ev_is_ask_q][i] == ev_price_q) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid_q[ev_is_ask_q][i] && !free) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
    cur_qty = lvl_qty_q[ev_is_ask_q][hit_idx];
    sum     = {1'b0, cur_qty} + {1'b0, ev_shares_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ev_is_ask_d = in_is_ask;
          ev_is_add_d = in_is_add;
          ev_price_d  = in_price;
          ev_shares_d = in_shares;
          state_d     = CALC;
        end
      end
      CALC: begin
        state_d = IDLE;
        if (ev_shares_q == '0) begin
          // Zero-share events never touch the table; a reduce of an unknown price still counts as a drop.
          drop_inc = !ev_is_add_q && !hit;
        end else if (ev_is_add_q) begin
          if (hit) begin
            emit     = 1'b1;
            emit_qty = sum[32] ? '1 : sum[31:0];
            lvl_qty_d[ev_is_ask_q][hit_idx] = emit_qty;
          end else if (free) begin
            emit     = 1'b1;
            emit_qty = ev_shares_q;
            valid_d[ev_is_ask_q][free_idx]     = 1'b1;
            lvl_price_d[ev_is_ask_q][free_idx] = ev_price_q;
            lvl_qty_d[ev_is_ask_q][free_idx]   = ev_shares_q;
          end else begin
            drop_inc = 1'b1;
          end
        end else if (!hit) begin
          drop_inc = 1'b1;
        end else if (ev_shares_q < cur_qty) begin
          emit     = 1'b1;
          emit_qty = cur_qty - ev_shares_q;
          lvl_qty_d[ev_is_ask_q][hit_idx] = emit_qty;
        end else begin
          emit     = 1'b1;
          emit_qty = '0;
          valid_d[ev_is_ask_q][hit_idx] = 1'b0;
          drop_inc = ev_shares_q > cur_qty;
        end

        if (emit) begin
          state_d      = EMIT;
          out_is_ask_d = ev_is_ask_q;
          out_price_d  = ev_price_q;
          out_qty_d    = emit_qty;
        end
        if (drop_inc && drop_q != '1) drop_d = drop_q + 16'd1;
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ev_is_ask_q  <= 1'b0;
      ev_is_add_q  <= 1'b0;
      ev_price_q   <= '0;
      ev_shares_q  <= '0;
      valid_q      <= '{default: '0};
      lvl_price_q  <= '{default: '0};
      lvl_qty_q    <= '{default: '0};
      out_is_ask_q <= 1'b0;
      out_price_q  <= '0;
      out_qty_q    <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      ev_is_ask_q  <= ev_is_ask_d;
      ev_is_add_q  <= ev_is_add_d;
      ev_price_q   <= ev_price_d;
      ev_shares_q  <= ev_shares_d;
      valid_q      <= valid_d;
      lvl_price_q  <= lvl_price_d;
      lvl_qty_q    <= lvl_qty_d;
      out_is_ask_q <= out_is_ask_d;
      out_price_q  <= out_price_d;
      out_qty_q    <= out_qty_d;
      drop_q       <= drop_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign update_valid = (state_q == EMIT);
  assign is_ask       = out_is_ask_q;
  assign price        = out_price_q;
  assign new_qty      = out_qty_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_book_level_update_tx.sv
// Directed bench for book_level_update_tx: hand-computed level updates,
// handshake timing, table-full, saturation and mid-operation reset.
module tb_book_level_update_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_ask;
  logic        in_is_add;
  logic [47:0] in_price;
  logic [31:0] in_shares;
  logic        update_valid;
  logic        is_ask;
  logic [47:0] price;
  logic [31:0] new_qty;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  book_level_update_tx #(.N_LEVELS(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_ask    (in_is_ask),
    .in_is_add    (in_is_add),
    .in_price     (in_price),
    .in_shares    (in_shares),
    .update_valid (update_valid),
    .is_ask       (is_ask),
    .price        (price),
    .new_qty      (new_qty),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One event: accept at posedge T, busy in T+1, pulse in T+2 (or ready again if no emit).
  task automatic ev(input logic ask, input logic add, input logic [47:0] p,
                    input logic [31:0] sh, input logic exp_emit, input logic [31:0] exp_qty);
    @(negedge clk);
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_is_ask = ask;
    in_is_add = add;
    in_price  = p;
    in_shares = sh;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", 64'({update_valid, in_ready}), 64'd0);
    @(negedge clk);
    if (exp_emit) begin
      chk("pulse", 64'(update_valid), 64'd1);
      chk("pulse_is_ask", 64'(is_ask), 64'(ask));
      chk("pulse_price", 64'(price), 64'(p));
      chk("pulse_qty", 64'(new_qty), 64'(exp_qty));
      @(negedge clk);
      chk("pulse_end_ready", 64'({update_valid, in_ready}), 64'b01);
    end else begin
      chk("no_pulse_ready", 64'({update_valid, in_ready}), 64'b01);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_is_ask = 1'b0;
    in_is_add = 1'b0;
    in_price  = '0;
    in_shares = '0;
    repeat (2) @(negedge clk);
    chk("rst_update_valid", 64'(update_valid), 64'd0);
    chk("rst_outputs", {15'd0, is_ask, price}, 64'd0);
    chk("rst_new_qty", 64'(new_qty), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Aggregation on one bid level
    ev(1'b0, 1'b1, 48'd100, 32'd50, 1'b1, 32'd50);
    ev(1'b0, 1'b1, 48'd100, 32'd25, 1'b1, 32'd75);

    // Ask level built up, drained to zero, then reduced while absent
    ev(1'b1, 1'b1, 48'd200, 32'd10, 1'b1, 32'd10);
    ev(1'b1, 1'b0, 48'd200, 32'd4,  1'b1, 32'd6);
    ev(1'b1, 1'b0, 48'd200, 32'd6,  1'b1, 32'd0);
    chk("drop_after_exact_drain", 64'(drop_count), 64'd0);
    ev(1'b1, 1'b0, 48'd200, 32'd1,  1'b0, 32'd0);
    chk("drop_missing_reduce", 64'(drop_count), 64'd1);

    // Empty the bid table, then fill it with 16 prices
    ev(1'b0, 1'b0, 48'd100, 32'd75, 1'b1, 32'd0);
    for (int i = 1; i <= 16; i++) ev(1'b0, 1'b1, 48'(i), 32'(i), 1'b1, 32'(i));
    ev(1'b0, 1'b1, 48'd17, 32'd5, 1'b0, 32'd0);
    chk("drop_table_full", 64'(drop_count), 64'd2);
    ev(1'b0, 1'b0, 48'd3, 32'd3, 1'b1, 32'd0);
    ev(1'b0, 1'b1, 48'd17, 32'd5, 1'b1, 32'd5);
    ev(1'b0, 1'b1, 48'd18, 32'd1, 1'b0, 32'd0);
    chk("drop_full_after_reuse", 64'(drop_count), 64'd3);
    ev(1'b0, 1'b1, 48'd17, 32'd2, 1'b1, 32'd7);

    do_reset();
    chk("drop_cleared", 64'(drop_count), 64'd0);

    // Saturation and exact full removal
    ev(1'b0, 1'b1, 48'd500, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0);
    ev(1'b0, 1'b1, 48'd500, 32'h0000_0100, 1'b1, 32'hFFFF_FFFF);
    ev(1'b0, 1'b0, 48'd500, 32'hFFFF_FFFF, 1'b1, 32'd0);
    chk("drop_after_sat", 64'(drop_count), 64'd0);

    // Over-reduce still emits zero but counts a drop
    ev(1'b0, 1'b1, 48'd600, 32'd5, 1'b1, 32'd5);
    ev(1'b0, 1'b0, 48'd600, 32'd9, 1'b1, 32'd0);
    chk("drop_over_reduce", 64'(drop_count), 64'd1);

    // Zero-share events
    ev(1'b0, 1'b1, 48'd700, 32'd0, 1'b0, 32'd0);
    ev(1'b0, 1'b1, 48'd800, 32'd4, 1'b1, 32'd4);
    ev(1'b0, 1'b0, 48'd800, 32'd0, 1'b0, 32'd0);
    ev(1'b0, 1'b0, 48'd800, 32'd4, 1'b1, 32'd0);
    chk("drop_zero_shares", 64'(drop_count), 64'd1);

    // Independent sides at the same price
    ev(1'b0, 1'b1, 48'd300, 32'd7, 1'b1, 32'd7);
    ev(1'b1, 1'b1, 48'd300, 32'd9, 1'b1, 32'd9);
    ev(1'b1, 1'b0, 48'd300, 32'd9, 1'b1, 32'd0);
    ev(1'b0, 1'b1, 48'd300, 32'd1, 1'b1, 32'd8);
    @(negedge clk);
    chk("hold_after_pulse", {is_ask, price[30:0], new_qty}, {1'b0, 31'd300, 32'd8});

    // Reset asserted while the event is in CALC
    @(negedge clk);
    in_valid  = 1'b1;
    in_is_ask = 1'b1;
    in_is_add = 1'b1;
    in_price  = 48'd42;
    in_shares = 32'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_no_pulse", 64'(update_valid), 64'd0);
    @(negedge clk);
    chk("midrst_no_pulse_2", 64'(update_valid), 64'd0);
    chk("midrst_qty", 64'(new_qty), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_drop", 64'(drop_count), 64'd0);
    ev(1'b1, 1'b0, 48'd42, 32'd1, 1'b0, 32'd0);
    chk("midrst_discarded", 64'(drop_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
